// File: rtl/hdc_pkg.sv
// hdc_pkg: shared HDC dimensions, derived widths and class-search FSM encoding.
package hdc_pkg;
  localparam int HDC_NUM_CLASSES = 8;
  localparam int HDC_NUM_FRAMES = 3;
  localparam int HDC_FRAME_W = 64;
  localparam int HDC_CID_W = $clog2(HDC_NUM_CLASSES);
  localparam int HDC_FID_W = $clog2(HDC_NUM_FRAMES);
  localparam int HDC_DIST_W = $clog2(HDC_NUM_FRAMES * HDC_FRAME_W + 1);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SCAN = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
endpackage

// File: rtl/frame_popcount.sv
// frame_popcount: combinational population count of one frame as a binary adder tree.
module frame_popcount #(
  parameter int W = 64
) (
  input  logic [W-1:0]             bits_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);
  localparam int N = 1 << $clog2(W);
  localparam int OW = $clog2(W + 1);
  // heap-ordered tree: node i sums children 2i and 2i+1, leaves start at N
  logic [OW-1:0] t [1:2*N-1];
  always_comb begin
    t = '{default: '0};
    for (int i = 0; i < W; i++) t[N+i] = OW'(bits_i[i]);
    for (int i = N - 1; i >= 1; i--) t[i] = t[2*i] + t[2*i+1];
  end
  assign cnt_o = t[1];
endmodule

// File: rtl/class_hvec_search.sv
// class_hvec_search: loads a query hypervector, scans all class vectors and returns
// the class with the smallest Hamming distance (ties resolved to the lower index).
module class_hvec_search
  import hdc_pkg::*;
#(
  parameter int NUM_CLASSES = HDC_NUM_CLASSES,
  parameter int NUM_FRAMES = HDC_NUM_FRAMES,
  parameter int FRAME_W = HDC_FRAME_W,
  parameter int CID_W = $clog2(NUM_CLASSES),
  parameter int FID_W = $clog2(NUM_FRAMES),
  parameter int DIST_W = $clog2(NUM_FRAMES * FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] query_frame,
  input  logic               query_valid,
  output logic               query_ready,
  output logic [CID_W-1:0]   frame_id,
  output logic [FID_W-1:0]   frame_index,
  input  logic [FRAME_W-1:0] class_vec_in,
  output logic [CID_W-1:0]   res_class,
  output logic [DIST_W-1:0]  res_dist,
  output logic               res_valid,
  input  logic               res_ready
);
  localparam int PC_W = $clog2(FRAME_W + 1);
  logic [2:0] state_q, state_d;
  logic [FRAME_W-1:0] query_q [NUM_FRAMES];
  logic [FID_W-1:0] beat_q, f_q;
  logic [CID_W-1:0] c_q;
  logic [PC_W-1:0] pc, pc_q;
  logic s1_v_q, s1_first_q, s1_last_q;
  logic [CID_W-1:0] s1_c_q, best_class_q, res_class_q;
  logic [DIST_W-1:0] acc_q, best_dist_q, res_dist_q, sum;
  logic beat_acc, last_beat, last_f, last_c, scan;
  assign scan = state_q == ST_SCAN;
  assign query_ready = ~rst & (state_q == ST_IDLE | state_q == ST_LOAD);
  assign beat_acc = query_valid & query_ready;
  assign last_beat = beat_q == FID_W'(NUM_FRAMES - 1);
  assign last_f = f_q == FID_W'(NUM_FRAMES - 1);
  assign last_c = c_q == CID_W'(NUM_CLASSES - 1);
  assign frame_id = scan ? c_q : '0;
  assign frame_index = scan ? f_q : '0;
  assign res_valid = state_q == ST_DONE;
  assign res_class = res_class_q;
  assign res_dist = res_dist_q;
  assign sum = (s1_first_q ? '0 : acc_q) + DIST_W'(pc_q);
  frame_popcount #(.W(FRAME_W)) u_pc (
    .bits_i(query_q[f_q] ^ class_vec_in),
    .cnt_o (pc)
  );
  // DRAIN waits for the final stage-1 beat to be folded into best before publishing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LOAD: state_d = beat_acc ? (last_beat ? ST_SCAN : ST_LOAD) : state_q;
      ST_SCAN:          state_d = (last_f && last_c) ? ST_DRAIN : ST_SCAN;
      ST_DRAIN:         state_d = s1_v_q ? ST_DRAIN : ST_DONE;
      ST_DONE:          state_d = res_ready ? ST_IDLE : ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (beat_acc) query_q[beat_q] <= query_frame;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q <= '0;
      f_q <= '0;
      c_q <= '0;
      s1_v_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_c_q <= '0;
      pc_q <= '0;
      acc_q <= '0;
      best_class_q <= '0;
      best_dist_q <= '0;
      res_class_q <= '0;
      res_dist_q <= '0;
    end else begin
      state_q <= state_d;
      if (beat_acc) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      if (beat_acc && last_beat) begin
        f_q <= '0;
        c_q <= '0;
      end else if (scan) begin
        f_q <= last_f ? '0 : f_q + 1'b1;
        if (last_f) c_q <= last_c ? '0 : c_q + 1'b1;
      end
      s1_v_q <= scan;
      pc_q <= pc;
      s1_c_q <= c_q;
      s1_first_q <= f_q == '0;
      s1_last_q <= last_f;
      if (s1_v_q) begin
        acc_q <= sum;
        if (s1_last_q && (s1_c_q == '0 || sum < best_dist_q)) begin
          best_class_q <= s1_c_q;
          best_dist_q <= sum;
        end
      end
      if (state_q == ST_DRAIN && state_d == ST_DONE) begin
        res_class_q <= best_class_q;
        res_dist_q <= best_dist_q;
      end
    end
  end
endmodule

// File: tb/tb_class_hvec_search.sv
// tb_class_hvec_search: directed checks of the class search against a stub class memory.
module tb_class_hvec_search;
  logic clk = 0, rst = 1;
  logic [63:0] query_frame = '0;
  logic query_valid = 0, query_ready, res_valid, res_ready = 1;
  logic [2:0] frame_id, res_class;
  logic [1:0] frame_index;
  logic [7:0] res_dist;
  logic [63:0] class_vec_in;
  logic [63:0] mem [8][3];
  logic [63:0] qbuf [3];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign class_vec_in = mem[frame_id][frame_index];
  class_hvec_search dut (
    .clk(clk), .rst(rst), .query_frame(query_frame), .query_valid(query_valid),
    .query_ready(query_ready), .frame_id(frame_id), .frame_index(frame_index),
    .class_vec_in(class_vec_in), .res_class(res_class), .res_dist(res_dist),
    .res_valid(res_valid), .res_ready(res_ready)
  );
  function automatic logic [63:0] mix(input int k);
    logic [63:0] x;
    x = 64'(k + 1) * 64'h9E3779B97F4A7C15;
    x = x ^ (x >> 31);
    x = x * 64'hBF58476D1CE4E5B9;
    x = x ^ (x >> 27);
    return x;
  endfunction
  function automatic int model_class();
    int best = 0, bd = 0, s;
    for (int c = 0; c < 8; c++) begin
      s = 0;
      for (int f = 0; f < 3; f++) s += $countones(qbuf[f] ^ mem[c][f]);
      if (c == 0 || s < bd) begin best = c; bd = s; end
    end
    return best;
  endfunction
  function automatic int model_dist();
    int bd = 0, s;
    for (int c = 0; c < 8; c++) begin
      s = 0;
      for (int f = 0; f < 3; f++) s += $countones(qbuf[f] ^ mem[c][f]);
      if (c == 0 || s < bd) bd = s;
    end
    return bd;
  endfunction
  task automatic load_class(input int c);
    for (int f = 0; f < 3; f++) qbuf[f] = mem[c][f];
  endtask
  task automatic send_query();
    for (int k = 0; k < 3; k++) begin
      query_frame = qbuf[k];
      query_valid = 1;
      @(posedge clk); #1;
    end
    query_valid = 0;
  endtask
  task automatic wait_result(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = n; break; end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (query_ready !== 1'b0) begin errors++; $display("FAIL reset_qready got %b exp 0", query_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if (res_class !== 3'd0 || res_dist !== 8'd0) begin errors++; $display("FAIL reset_res got %0d/%0d exp 0/0", res_class, res_dist); end
    checks++; if (frame_id !== 3'd0 || frame_index !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d exp 0/0", frame_id, frame_index); end
    rst = 0;
    #1;
    checks++; if (query_ready !== 1'b1) begin errors++; $display("FAIL post_reset_qready got %b exp 1", query_ready); end
  endtask
  task automatic test_exact_match();
    int lat;
    load_class(5);
    send_query();
    wait_result(lat);
    checks++; if (lat !== 26) begin errors++; $display("FAIL exact_latency got %0d exp 26", lat); end
    checks++; if (res_class !== 3'd5) begin errors++; $display("FAIL exact_class got %0d exp 5", res_class); end
    checks++; if (res_dist !== 8'd0) begin errors++; $display("FAIL exact_dist got %0d exp 0", res_dist); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || query_ready !== 1'b1) begin errors++; $display("FAIL exact_release got valid %b ready %b exp 0 1", res_valid, query_ready); end
  endtask
  task automatic test_address_sweep();
    int bad = 0;
    load_class(1);
    checks++; if (frame_id !== 3'd0 || frame_index !== 2'd0) begin errors++; $display("FAIL idle_addr got %0d/%0d exp 0/0", frame_id, frame_index); end
    send_query();
    for (int n = 0; n < 26; n++) begin
      if (n < 24 ? (frame_id !== 3'(n / 3) || frame_index !== 2'(n % 3)) : (frame_id !== 3'd0 || frame_index !== 2'd0)) begin
        bad++;
        $display("FAIL sweep_addr cycle %0d got %0d/%0d exp %0d/%0d", n, frame_id, frame_index, n < 24 ? n / 3 : 0, n < 24 ? n % 3 : 0);
      end
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) errors++;
    checks++; if (res_valid !== 1'b1 || res_class !== 3'd1 || res_dist !== 8'd0) begin errors++; $display("FAIL sweep_result got v%b %0d/%0d exp v1 1/0", res_valid, res_class, res_dist); end
    @(posedge clk); #1;
  endtask
  task automatic test_flipped();
    int lat;
    load_class(3);
    qbuf[1] = qbuf[1] ^ 64'h8000_0100_0010_0001;
    send_query();
    wait_result(lat);
    checks++; if (lat !== 26) begin errors++; $display("FAIL flip_latency got %0d exp 26", lat); end
    checks++; if (res_class !== 3'd3 || res_dist !== 8'd4) begin errors++; $display("FAIL flip_result got %0d/%0d exp 3/4", res_class, res_dist); end
    checks++; if (int'(res_class) !== model_class() || int'(res_dist) !== model_dist()) begin errors++; $display("FAIL flip_model got %0d/%0d exp %0d/%0d", res_class, res_dist, model_class(), model_dist()); end
    @(posedge clk); #1;
  endtask
  task automatic test_mid_reset();
    int lat;
    load_class(6);
    send_query();
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (frame_id !== 3'd3 || frame_index !== 2'd1) begin errors++; $display("FAIL scan10_addr got %0d/%0d exp 3/1", frame_id, frame_index); end
    rst = 1;
    @(posedge clk); #1;
    checks++; if (frame_id !== 3'd0 || frame_index !== 2'd0 || query_ready !== 1'b0) begin errors++; $display("FAIL midrst_addr got %0d/%0d ready %b exp 0/0 0", frame_id, frame_index, query_ready); end
    checks++; if (res_valid !== 1'b0 || res_class !== 3'd0 || res_dist !== 8'd0) begin errors++; $display("FAIL midrst_res got v%b %0d/%0d exp v0 0/0", res_valid, res_class, res_dist); end
    rst = 0;
    load_class(3);
    qbuf[1] = qbuf[1] ^ 64'h8000_0100_0010_0001;
    send_query();
    wait_result(lat);
    checks++; if (lat !== 26 || res_class !== 3'd3 || res_dist !== 8'd4) begin errors++; $display("FAIL midrst_fresh got lat %0d %0d/%0d exp 26 3/4", lat, res_class, res_dist); end
  endtask
  task automatic test_backpressure();
    int lat, bad = 0;
    @(posedge clk); #1;
    res_ready = 0;
    load_class(3);
    qbuf[1] = qbuf[1] ^ 64'h8000_0100_0010_0001;
    send_query();
    wait_result(lat);
    checks++; if (lat !== 26) begin errors++; $display("FAIL bp_latency got %0d exp 26", lat); end
    query_frame = 64'hFFFF_0000_FFFF_0000;
    query_valid = 1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_class !== 3'd3 || res_dist !== 8'd4 || query_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d got v%b %0d/%0d ready %b exp v1 3/4 0", n, res_valid, res_class, res_dist, query_ready);
      end
    end
    checks++; if (bad !== 0) errors++;
    res_ready = 1;
    @(posedge clk); #1;
    query_valid = 0;
    checks++; if (res_valid !== 1'b0 || query_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v%b ready %b exp 0 1", res_valid, query_ready); end
    load_class(5);
    send_query();
    wait_result(lat);
    checks++; if (lat !== 26 || res_class !== 3'd5 || res_dist !== 8'd0) begin errors++; $display("FAIL bp_no_consume got lat %0d %0d/%0d exp 26 5/0", lat, res_class, res_dist); end
    @(posedge clk); #1;
  endtask
  task automatic test_tie();
    int lat;
    for (int f = 0; f < 3; f++) mem[6][f] = mem[2][f];
    load_class(2);
    qbuf[0] = qbuf[0] ^ 64'h80;
    send_query();
    wait_result(lat);
    checks++; if (res_class !== 3'd2 || res_dist !== 8'd1) begin errors++; $display("FAIL tie_result got %0d/%0d exp 2/1", res_class, res_dist); end
    checks++; if (int'(res_class) !== model_class() || int'(res_dist) !== model_dist()) begin errors++; $display("FAIL tie_model got %0d/%0d exp %0d/%0d", res_class, res_dist, model_class(), model_dist()); end
    @(posedge clk); #1;
  endtask
  initial begin
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 3; f++) mem[c][f] = mix(c * 3 + f);
    test_reset();
    test_exact_match();
    test_address_sweep();
    test_flipped();
    test_mid_reset();
    test_backpressure();
    test_tie();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
